// File: rtl/mcmm_pkg.sv
// Shared types and constants for the multicore matrix-multiply run sequencer.
package mcmm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DONE,
    ERR
  } run_state_t;

  localparam int MAX_CORES = 16;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear/enable.
// tc_o flags that the next enabled increment lands on TIMEOUT, so a caller that
// acts on tc_o in the same cycle sees count_o == TIMEOUT in the following state.
module run_cycle_counter
  import mcmm_pkg::*;
#(
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CYC_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [CYC_W-1:0] TC_VAL = CYC_W'(TIMEOUT - 1);

  logic [CYC_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise increment until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign tc_o    = (cnt_q >= TC_VAL);

endmodule

// File: rtl/multicore_run_ctrl.sv
// Run sequencer: pulses START to the enabled cores on a host go, latches each
// core's END, and reports done (with elapsed cycles) once all enabled cores end.
// Optional watchdog: define RUN_TIMEOUT_EN to enable the RUN -> ERR timeout.
module multicore_run_ctrl
  import mcmm_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int START_LEN = 1,
  parameter int CYC_W     = 32,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 go,
  input  logic [NUM_CORES-1:0] core_en,
  input  logic [NUM_CORES-1:0] core_end,
  output logic [NUM_CORES-1:0] core_start,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [NUM_CORES-1:0] end_mask,
  output logic [CYC_W-1:0]     cycle_count
);

  localparam logic [15:0] SLEN_LAST = 16'(START_LEN - 1);

  run_state_t           state_q;
  logic [NUM_CORES-1:0] en_q, end_mask_q, start_q;
  logic [NUM_CORES-1:0] end_mask_nx;
  logic [15:0]          slen_q;
  logic                 busy_q, done_q, err_q;
  logic                 cnt_clr, cnt_en, tc;

  // ENDs from disabled cores are masked off before they reach the sticky mask
  assign end_mask_nx = end_mask_q | (core_end & en_q);
  assign cnt_clr     = (state_q == IDLE) && go;
  assign cnt_en      = (state_q == START) || (state_q == RUN);

  run_cycle_counter #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk     (clk),
    .RESET   (RESET),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cycle_count),
    .tc_o    (tc)
  );

`ifndef RUN_TIMEOUT_EN
  logic unused_tc;
  assign unused_tc = tc;
`endif

  // run sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      en_q       <= '0;
      end_mask_q <= '0;
      start_q    <= '0;
      slen_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            en_q       <= core_en;
            end_mask_q <= '0;
            slen_q     <= '0;
            if (core_en != '0) begin
              state_q <= START;
              start_q <= core_en;
              busy_q  <= 1'b1;
            end else begin
              // nothing enabled: finish at once with a zero cycle count
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        START: begin
          // an END arriving during the pulse still counts
          end_mask_q <= end_mask_nx;
          if (slen_q == SLEN_LAST) begin
            state_q <= RUN;
            start_q <= '0;
          end else begin
            slen_q <= slen_q + 1'b1;
          end
        end
        RUN: begin
          end_mask_q <= end_mask_nx;
          if (end_mask_nx == en_q) begin
            // completion beats a timeout landing in the same cycle
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef RUN_TIMEOUT_EN
          else if (tc) begin
            state_q <= ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
`endif
        end
        DONE: begin
          // go must drop before another run can be accepted
          if (!go) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        ERR: begin
          if (!go) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_start  = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign end_mask    = end_mask_q;

endmodule

// File: tb/tb_multicore_run_ctrl.sv
// Self-checking bench for multicore_run_ctrl: directed runs plus a scoreboard of
// expected {end_mask, cycle_count} popped on each rising done.
module tb_multicore_run_ctrl;

  localparam int NC = 4;
  localparam int SL = 1;
  localparam int CW = 32;
`ifdef RUN_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          RESET, go;
  logic [NC-1:0] core_en, core_end, core_start, end_mask;
  logic          busy, done, timeout_err;
  logic [CW-1:0] cycle_count;

  typedef struct packed {
    logic [NC-1:0] mask;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  multicore_run_ctrl #(
    .NUM_CORES (NC),
    .START_LEN (SL),
    .CYC_W     (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .go          (go),
    .core_en     (core_en),
    .core_end    (core_end),
    .core_start  (core_start),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .end_mask    (end_mask),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go(input logic [NC-1:0] en);
    core_en = en;
    go      = 1'b1;
    tick();
    go      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  // scoreboard monitor: compare on each rising done
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_end_mask", end_mask, e.mask);
          chk("sb_cycle_count", cycle_count, e.cnt);
        end
      end
      done_prev = done;
    end
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit seen;
    int n;
    RESET = 1'b1; go = 1'b0; core_en = '0; core_end = '0;

    // 1: reset state
    tick(); tick();
    RESET = 1'b0;
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_end_mask", end_mask, 0);
    chk("rst_cycle_count", cycle_count, 0);

    // 1/2: all four cores, ENDs staggered at 5,9,12,20
    sb.push_back('{mask: 4'b1111, cnt: 20});
    do_go(4'b1111);
    chk("t1_start_pulse", core_start, 4'b1111);
    chk("t1_busy", busy, 1);
    for (int e = 1; e <= 22; e++) begin
      if (e == 5)  core_end[0] = 1'b1;
      if (e == 9)  core_end[1] = 1'b1;
      if (e == 12) core_end[2] = 1'b1;
      if (e == 20) core_end[3] = 1'b1;
      tick();
      if (e == 1)  chk("t1_start_len", core_start, 0);
      if (e == 19) chk("t2_not_done_yet", done, 0);
      if (e == 20) chk("t2_done_at_21", done, 1);
      if (e == 20) chk("t2_busy_low", busy, 0);
    end
    core_end = '0;

    // 3: disabled cores' ENDs ignored
    n = 30;
    sb.push_back('{mask: 4'b0101, cnt: CW'(n + 1)});
    core_end = 4'b1010;
    do_go(4'b0101);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("t3_never_done", seen, 0);
    chk("t3_mask_partial", end_mask, 0);
    core_end = 4'b1111;
    tick();
    chk("t3_done_next", done, 1);
    core_end = '0;
    tick(); tick();

    // 4: empty enable mask finishes immediately
    sb.push_back('{mask: 4'b0000, cnt: 0});
    do_go(4'b0000);
    chk("t4_done", done, 1);
    chk("t4_no_pulse", core_start, 0);
    chk("t4_busy", busy, 0);
    tick(); tick();

    // 5: reset mid-run, then a clean run with END in the first START cycle
    do_go(4'b1111);
    repeat (5) tick();
    chk("t5_busy_mid", busy, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    sb.delete();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_start", core_start, 0);
    chk("t5_rst_mask", end_mask, 0);
    chk("t5_rst_count", cycle_count, 0);
    sb.push_back('{mask: 4'b0011, cnt: 2});
    do_go(4'b0011);
    core_end = 4'b0011;
    tick();
    chk("t5_early_end_latched", end_mask, 4'b0011);
    tick();
    chk("t5_clean_done", done, 1);
    core_end = '0;
    tick(); tick();

    // go held high through DONE must not retrigger
    sb.push_back('{mask: 4'b0001, cnt: 2});
    core_en  = 4'b0001;
    core_end = 4'b0001;
    go       = 1'b1;
    tick();
    wait_done("t7_done", 10);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (busy || !done) seen = 1'b1;
    end
    chk("t7_no_retrigger", seen, 0);
    go = 1'b0;
    tick();
    chk("t7_back_idle", done, 0);
    sb.push_back('{mask: 4'b0001, cnt: 2});
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("t7_new_run_busy", busy, 1);
    wait_done("t7_done2", 10);
    core_end = '0;
    tick(); tick();

`ifdef RUN_TIMEOUT_EN
    // 6: watchdog, core 2 hangs; go held high through ERR
    core_en  = 4'b1111;
    core_end = 4'b1011;
    go       = 1'b1;
    tick();
    n = 0;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    chk("t6_err", timeout_err, 1);
    chk("t6_err_count", cycle_count, TO);
    chk("t6_err_mask", end_mask, 4'b1011);
    chk("t6_err_busy", busy, 0);
    repeat (3) tick();
    chk("t6_err_held", timeout_err, 1);
    go = 1'b0;
    tick();
    chk("t6_err_clear", timeout_err, 0);
    core_end = '0;
    tick();
`endif

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
